// File: rtl/pattern_detector.sv
// Parametrised serial bit-pattern detector with a reloadable pattern, overlap and Moore/Mealy selection.
// Define PATTERN_DETECTOR_MATCH_CNT_EN to add the saturating match_cnt output and its CNT_W parameter.
module pattern_detector #(
  parameter int N = 6,
  parameter logic [N-1:0] PATTERN = 6'b101101
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     X,
  input  logic                     valid,
  input  logic                     M,
  input  logic                     OV,
  input  logic                     pat_ld,
  input  logic [N-1:0]             pat_in,
  output logic [$clog2(N+1)-1:0]   Q,
  output logic                     Z
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]         match_cnt
`endif
);

  localparam int QW = $clog2(N+1);

  logic [N-1:0]  r_pat;
  // The oldest history bit is shifted out before it is ever compared, so only N-1 bits are kept.
  logic [N-2:0]  r_hist;
  logic [QW-1:0] r_avail;
  logic [QW-1:0] r_q;
  logic          r_zm;

  logic [N-1:0]  w_h;
  logic [QW-1:0] w_avail_next;
  logic [QW-1:0] w_q_next;
  logic [N-1:1]  w_pref_eq;
  logic          w_full_eq;
  logic          w_hit;

  assign w_h          = {r_hist, X};
  assign w_avail_next = (r_avail == QW'(N)) ? QW'(N) : r_avail + 1'b1;
  assign w_full_eq    = (w_h == r_pat);
  assign w_hit        = valid & ~pat_ld & (w_avail_next == QW'(N)) & w_full_eq;

  // One comparator per candidate overlap length; stale history beyond avail is masked out.
  for (genvar gi = 1; gi < N; gi++) begin : g_pref
    assign w_pref_eq[gi] = (w_h[gi-1:0] == r_pat[N-1 -: gi]) && (QW'(gi) <= w_avail_next);
  end

  always_comb begin
    w_q_next = '0;
    for (int k = 1; k < N; k++) begin
      if (w_pref_eq[k]) w_q_next = QW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_avail <= '0;
      r_q     <= '0;
      r_zm    <= 1'b0;
    end else if (pat_ld) begin
      r_pat   <= pat_in;
      r_hist  <= '0;
      r_avail <= '0;
      r_q     <= '0;
      r_zm    <= 1'b0;
    end else if (valid) begin
      r_hist <= w_h[N-2:0];
      r_zm   <= w_hit;
      if (w_hit && !OV) begin
        r_avail <= '0;
        r_q     <= '0;
      end else begin
        r_avail <= w_avail_next;
        r_q     <= w_q_next;
      end
    end
  end

  assign Z = M ? w_hit : r_zm;
  assign Q = r_q;

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Only reset clears the count; loading a new pattern keeps the running total.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_cnt <= '0;
    end else if (w_hit && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: constant vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pattern_detector;
  localparam int N = 6;
  localparam logic [N-1:0] PAT0 = 6'b101101;
  localparam int QW = $clog2(N+1);

  logic clk = 1'b0;
  logic reset, X, valid, M, OV, pat_ld;
  logic [N-1:0] pat_in;
  logic [QW-1:0] Q;
  logic Z;
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  localparam int CW = 2;
  logic [CW-1:0] match_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int txn = 0;

  always #5 clk = ~clk;

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  pattern_detector #(.N(N), .PATTERN(PAT0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .X(X), .valid(valid), .M(M), .OV(OV),
    .pat_ld(pat_ld), .pat_in(pat_in), .Q(Q), .Z(Z), .match_cnt(match_cnt)
  );
`else
  pattern_detector #(.N(N), .PATTERN(PAT0)) dut (
    .clk(clk), .reset(reset), .X(X), .valid(valid), .M(M), .OV(OV),
    .pat_ld(pat_ld), .pat_in(pat_in), .Q(Q), .Z(Z)
  );
`endif

  // Reference model: the accepted bits since the last restart (last N kept), pattern, Moore flag.
  bit           m_bits[$];
  logic [N-1:0] m_pat = PAT0;
  bit           m_zm = 1'b0;

  // Longest k (<= maxk) such that the last k bits of s equal the first k pattern bits.
  function automatic int sfx_pref(input bit s[$], input logic [N-1:0] p, input int maxk);
    for (int k = maxk; k >= 1; k--) begin
      if (k <= s.size()) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (s[s.size()-k+i] != p[N-1-i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input bit rst, ld, input logic [N-1:0] pin, input bit v, x, m, ov,
                            output bit ez, output int eq);
    bit cand[$];
    bit hit;
    cand = m_bits;
    cand.push_back(x);
    if (cand.size() > N) void'(cand.pop_front());
    hit = v && !ld && (sfx_pref(cand, m_pat, N) == N);
    ez = m ? hit : m_zm;
    if (rst) begin
      m_bits.delete(); m_pat = PAT0; m_zm = 1'b0;
    end else if (ld) begin
      m_bits.delete(); m_pat = pin; m_zm = 1'b0;
    end else if (v) begin
      m_zm = hit;
      if (hit && !ov) m_bits.delete();
      else m_bits = cand;
    end
    eq = sfx_pref(m_bits, m_pat, N-1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive just after the rising edge, sample Z at the falling edge, Q just after the next rising edge.
  task automatic step(input string nm, input bit rst, ld, input logic [N-1:0] pin, input bit v, x, m, ov,
                      output logic zo, output logic [QW-1:0] qo);
    bit ez;
    int eq;
    model_step(rst, ld, pin, v, x, m, ov, ez, eq);
    reset = rst; pat_ld = ld; pat_in = pin; valid = v; X = x; M = m; OV = ov;
    @(negedge clk);
    zo = Z;
    @(posedge clk);
    #1;
    qo = Q;
    txn++;
    $display("txn %0d %s rst=%0b ld=%0b v=%0b x=%0b M=%0b OV=%0b Z=%0b Q=%0d", txn, nm, rst, ld, v, x, m, ov, zo, qo);
    if (!rst) chk({nm, "_z_model"}, 32'(zo), 32'(ez));
    chk({nm, "_q_model"}, 32'(qo), 32'(eq));
  endtask

  typedef struct {
    bit rst, ld;
    logic [N-1:0] pin;
    bit v, x, m, ov, cz;
    bit ez;
    int eq;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_row(bit rst, ld, logic [N-1:0] pin, bit v, x, m, ov, cz, ez, int eq);
    vec_t r;
    r.rst = rst; r.ld = ld; r.pin = pin; r.v = v; r.x = x; r.m = m; r.ov = ov;
    r.cz = cz; r.ez = ez; r.eq = eq;
    tbl.push_back(r);
  endfunction

  // n Mealy-mode bits, first bit at index n-1; expected Q given as one hex nibble per bit.
  function automatic void add_bits(int n, logic [15:0] xs, logic [15:0] zs, bit ov, logic [63:0] qs);
    for (int i = 0; i < n; i++)
      add_row(1'b0, 1'b0, '0, 1'b1, xs[n-1-i], 1'b1, ov, 1'b1, zs[n-1-i], int'(qs[4*(n-1-i) +: 4]));
  endfunction

  logic zo;
  logic [QW-1:0] qo;
  int hits;

  initial begin
    reset = 1'b1; pat_ld = 1'b0; pat_in = '0; valid = 1'b0; X = 1'b0; M = 1'b1; OV = 1'b0;
    @(posedge clk);
    #1;

    // Vector table: streams from the default pattern, overlap on/off, reset mid-pattern, pattern reload.
    add_row(1, 0, '0, 0, 0, 1, 0, 0, 0, 0);
    add_bits(9, 16'b101101101, 16'b000001000, 1'b0, 64'h123450123);
    add_row(1, 0, '0, 0, 0, 1, 1, 0, 0, 0);
    add_bits(9, 16'b101101101, 16'b000001001, 1'b1, 64'h123453453);
    add_row(1, 0, '0, 0, 0, 1, 0, 0, 0, 0);
    add_bits(4, 16'b1011, 16'b0000, 1'b0, 64'h1234);
    add_row(1, 0, '0, 1, 1, 1, 0, 0, 0, 0);
    add_bits(2, 16'b01, 16'b00, 1'b0, 64'h01);
    add_row(0, 1, 6'b111000, 1, 1, 1, 0, 1, 0, 0);
    add_bits(6, 16'b111000, 16'b000001, 1'b0, 64'h123450);

    foreach (tbl[i]) begin
      step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].ld, tbl[i].pin, tbl[i].v, tbl[i].x,
           tbl[i].m, tbl[i].ov, zo, qo);
      if (tbl[i].cz) chk($sformatf("tbl%0d_z", i), 32'(zo), 32'(tbl[i].ez));
      chk($sformatf("tbl%0d_q", i), 32'(qo), 32'(tbl[i].eq));
    end

    // Moore: flag rises a clock after the completing bit and holds across idle cycles.
    step("moore_rst", 1, 0, '0, 0, 0, 0, 0, zo, qo);
    chk("moore_rst_q", 32'(qo), 0);
    begin
      logic [5:0] s = 6'b101101;
      for (int i = 5; i >= 0; i--) step("moore_bit", 0, 0, '0, 1, s[i], 0, 0, zo, qo);
    end
    chk("moore_edge_z", 32'(zo), 0);
    for (int i = 0; i < 3; i++) begin
      step("moore_idle", 0, 0, '0, 0, i[0], 0, 0, zo, qo);
      chk("moore_idle_z", 32'(zo), 1);
    end
    step("moore_next", 0, 0, '0, 1, 0, 0, 0, zo, qo);
    chk("moore_next_z", 32'(zo), 1);
    step("moore_after", 0, 0, '0, 0, 0, 0, 0, zo, qo);
    chk("moore_after_z", 32'(zo), 0);

    // Gapped valid with X toggling during the gaps.
    step("gap_rst", 1, 0, '0, 0, 0, 1, 0, zo, qo);
    hits = 0;
    begin
      logic [5:0] s = 6'b101101;
      for (int i = 5; i >= 0; i--) begin
        step("gap_bit", 0, 0, '0, 1, s[i], 1, 0, zo, qo);
        hits += int'(zo);
        step("gap_idle", 0, 0, '0, 0, ~s[i], 1, 0, zo, qo);
        hits += int'(zo);
      end
    end
    chk("gap_hits", 32'(hits), 1);

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    // Counter saturates at 3 with a 2-bit width, survives pat_ld, clears on reset.
    step("cnt_rst", 1, 0, '0, 0, 0, 1, 1, zo, qo);
    chk("cnt_rst_val", 32'(match_cnt), 0);
    for (int r = 0; r < 6; r++) begin
      step("cnt_bit", 0, 0, '0, 1, 1, 1, 1, zo, qo);
      step("cnt_bit", 0, 0, '0, 1, 0, 1, 1, zo, qo);
      step("cnt_bit", 0, 0, '0, 1, 1, 1, 1, zo, qo);
    end
    chk("cnt_sat", 32'(match_cnt), 3);
    step("cnt_ld", 0, 1, PAT0, 1, 1, 1, 1, zo, qo);
    chk("cnt_after_ld", 32'(match_cnt), 3);
    step("cnt_rst2", 1, 0, '0, 0, 0, 1, 1, zo, qo);
    chk("cnt_cleared", 32'(match_cnt), 0);
`endif

    // Randomized traffic against the reference model, biased toward the active pattern.
    begin
      bit m = 1'b1, ov = 1'b0;
      int pos = 0;
      for (int i = 0; i < 1500; i++) begin
        bit rst = ($urandom_range(0, 149) == 0);
        bit ld = ($urandom_range(0, 39) == 0);
        bit v = ($urandom_range(0, 3) != 0);
        bit x;
        logic [N-1:0] pin = N'($urandom);
        if ($urandom_range(0, 19) == 0) m = ~m;
        if ($urandom_range(0, 19) == 0) ov = ~ov;
        x = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pat[N-1-(pos % N)];
        if (v) pos++;
        step("rnd", rst, ld, pin, v, x, m, ov, zo, qo);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
